// File: rtl/execute_multicycle_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : execute_multicycle_sequencer_pkg
// Description : Shared state type and sizing helper for the multi-cycle
//               execute sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package execute_multicycle_sequencer_pkg;

    typedef enum logic [1:0] {
        MC_IDLE  = 2'd0,
        MC_WAIT  = 2'd1,
        MC_DONE  = 2'd2,
        MC_DRAIN = 2'd3
    } mc_state_type;

    // A disabled watchdog still keeps a 1-bit saturating counter.
    function automatic int mc_cnt_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/execute_multicycle_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : execute_multicycle_sequencer_if
// Description : Request, unit and result signals of the multi-cycle sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface execute_multicycle_sequencer_if #(
    parameter int NUM_UNITS = 4,
    parameter int XLEN      = 32,
    parameter int OPW       = 8,
    parameter int FLAGW     = 5
);
    localparam int c_IDX_W = $clog2(NUM_UNITS) + 1;

    logic                       req_valid;
    logic [c_IDX_W-1:0]         req_unit;
    logic [XLEN-1:0]            req_data1;
    logic [XLEN-1:0]            req_data2;
    logic [XLEN-1:0]            req_data3;
    logic [OPW-1:0]             req_op;
    logic                       clear;
    logic                       hold;
    logic [NUM_UNITS-1:0]       unit_enable;
    logic [XLEN-1:0]            unit_data1;
    logic [XLEN-1:0]            unit_data2;
    logic [XLEN-1:0]            unit_data3;
    logic [OPW-1:0]             unit_op;
    logic [NUM_UNITS-1:0]       unit_ready;
    logic [NUM_UNITS*XLEN-1:0]  unit_result;
    logic [NUM_UNITS*FLAGW-1:0] unit_flags;
    logic                       stall;
    logic                       res_valid;
    logic [XLEN-1:0]            res_data;
    logic [FLAGW-1:0]           res_flags;
    logic                       res_error;
    logic                       busy;

    modport master (
        output req_valid, req_unit, req_data1, req_data2, req_data3, req_op,
        output clear, hold, unit_ready, unit_result, unit_flags,
        input  unit_enable, unit_data1, unit_data2, unit_data3, unit_op,
        input  stall, res_valid, res_data, res_flags, res_error, busy
    );

    modport slave (
        input  req_valid, req_unit, req_data1, req_data2, req_data3, req_op,
        input  clear, hold, unit_ready, unit_result, unit_flags,
        output unit_enable, unit_data1, unit_data2, unit_data3, unit_op,
        output stall, res_valid, res_data, res_flags, res_error, busy
    );

endinterface

`default_nettype wire

// File: rtl/execute_multicycle_sequencer_onehot_mux.sv
`default_nettype none
// ============================================================================
// Module      : mc_onehot_mux
// Description : AND-OR selection of one W-bit slice by a one-hot select.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_onehot_mux #(
    parameter int NUM_UNITS = 4,
    parameter int W         = 37
) (
    input  wire logic [NUM_UNITS-1:0]   i_sel,
    input  wire logic [NUM_UNITS*W-1:0] i_data,
    output logic      [W-1:0]           o_data
);

    // An all-zero select yields zero, which the sequencer never captures.
    always_comb begin
        o_data = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (i_sel[k]) begin
                o_data = o_data | i_data[k*W +: W];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/execute_multicycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : execute_multicycle_sequencer
// Description : Single FSM driving enable/operand hold, result capture,
//               flush drain and watchdog for NUM_UNITS multi-cycle units.
// Revision    : 1.0 - initial release
// ============================================================================
module execute_multicycle_sequencer
    import execute_multicycle_sequencer_pkg::*;
#(
    parameter int NUM_UNITS = 4,
    parameter int XLEN      = 32,
    parameter int OPW       = 8,
    parameter int FLAGW     = 5,
    parameter int TIMEOUT   = 64
) (
    input  wire logic                     clock,
    input  wire logic                     reset,
    execute_multicycle_sequencer_if.slave bus
);

    localparam int c_IDX_W = $clog2(NUM_UNITS) + 1;
    localparam int c_CNT_W = mc_cnt_width(TIMEOUT);
    localparam int c_MUX_W = XLEN + FLAGW;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef struct packed {
        logic [c_IDX_W-1:0] unit;
        logic [XLEN-1:0]    data1;
        logic [XLEN-1:0]    data2;
        logic [XLEN-1:0]    data3;
        logic [OPW-1:0]     op;
    } mc_req_type;

    typedef struct packed {
        mc_state_type         state;
        logic [NUM_UNITS-1:0] sel;
        logic [NUM_UNITS-1:0] enable;
        logic [XLEN-1:0]      data1;
        logic [XLEN-1:0]      data2;
        logic [XLEN-1:0]      data3;
        logic [OPW-1:0]       op;
        logic [c_CNT_W-1:0]   cnt;
        logic                 res_valid;
        logic                 res_error;
        logic [XLEN-1:0]      res_data;
        logic [FLAGW-1:0]     res_flags;
    } mc_reg_type;

    localparam mc_reg_type c_INIT_MC_REG = '{state: MC_IDLE, default: '0};

    mc_reg_type                 r_mc;
    mc_reg_type                 w_mc;
    mc_req_type                 w_req;
    logic [NUM_UNITS-1:0]       w_onehot;
    logic                       w_unit_ok;
    logic                       w_ready;
    logic                       w_timeout;
    logic [c_CNT_W-1:0]         w_cnt_inc;
    logic [NUM_UNITS*c_MUX_W-1:0] w_mux_in;
    logic [c_MUX_W-1:0]         w_mux_out;

    assign w_req = '{unit:  bus.req_unit,
                     data1: bus.req_data1,
                     data2: bus.req_data2,
                     data3: bus.req_data3,
                     op:    bus.req_op};

    always_comb begin
        w_onehot = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            w_onehot[k] = (w_req.unit == c_IDX_W'(k));
        end
    end

    assign w_unit_ok = (w_req.unit < c_IDX_W'(NUM_UNITS));
    assign w_ready   = |(bus.unit_ready & r_mc.sel);
    assign w_timeout = (TIMEOUT != 0) && (r_mc.cnt == c_CNT_LAST);
    assign w_cnt_inc = (&r_mc.cnt) ? r_mc.cnt : r_mc.cnt + 1'b1;

    for (genvar k = 0; k < NUM_UNITS; k++) begin : g_pack
        assign w_mux_in[k*c_MUX_W +: c_MUX_W] = {bus.unit_result[k*XLEN +: XLEN],
                                                 bus.unit_flags[k*FLAGW +: FLAGW]};
    end

    mc_onehot_mux #(
        .NUM_UNITS (NUM_UNITS),
        .W         (c_MUX_W)
    ) u_result_mux (
        .i_sel  (r_mc.sel),
        .i_data (w_mux_in),
        .o_data (w_mux_out)
    );

    always_comb begin
        w_mc = r_mc;
        case (r_mc.state)
            MC_IDLE: begin
                if (bus.req_valid && !bus.clear) begin
                    if (w_unit_ok) begin
                        w_mc.state  = MC_WAIT;
                        w_mc.sel    = w_onehot;
                        w_mc.enable = w_onehot;
                        w_mc.data1  = w_req.data1;
                        w_mc.data2  = w_req.data2;
                        w_mc.data3  = w_req.data3;
                        w_mc.op     = w_req.op;
                        w_mc.cnt    = '0;
                    end else begin
                        w_mc.state     = MC_DONE;
                        w_mc.sel       = '0;
                        w_mc.res_valid = 1'b1;
                        w_mc.res_error = 1'b1;
                        w_mc.res_data  = '0;
                        w_mc.res_flags = '0;
                    end
                end
            end
            MC_WAIT: begin
                w_mc.cnt = w_cnt_inc;
                // A flush wins over both completion and the watchdog.
                if (bus.clear) begin
                    w_mc.enable = '0;
                    w_mc.cnt    = '0;
                    w_mc.state  = w_ready ? MC_IDLE : MC_DRAIN;
                end else if (w_ready) begin
                    w_mc.enable    = '0;
                    w_mc.state     = MC_DONE;
                    w_mc.res_valid = 1'b1;
                    w_mc.res_error = 1'b0;
                    {w_mc.res_data, w_mc.res_flags} = w_mux_out;
                end else if (w_timeout) begin
                    w_mc.enable    = '0;
                    w_mc.state     = MC_DONE;
                    w_mc.res_valid = 1'b1;
                    w_mc.res_error = 1'b1;
                    w_mc.res_data  = '0;
                    w_mc.res_flags = '0;
                end
            end
            MC_DONE: begin
                if (!bus.hold || bus.clear) begin
                    w_mc.state     = MC_IDLE;
                    w_mc.res_valid = 1'b0;
                    w_mc.res_error = 1'b0;
                    w_mc.res_data  = '0;
                    w_mc.res_flags = '0;
                end
            end
            MC_DRAIN: begin
                w_mc.cnt = w_cnt_inc;
                if (w_ready || w_timeout) begin
                    w_mc.state = MC_IDLE;
                end
            end
            default: begin
                w_mc = c_INIT_MC_REG;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_mc <= c_INIT_MC_REG;
        end else begin
            r_mc <= w_mc;
        end
    end

    // Gated by reset so every output reads zero while reset is held.
    assign bus.stall = reset & (((r_mc.state == MC_IDLE) & bus.req_valid & ~bus.clear) |
                                (r_mc.state == MC_WAIT) |
                                ((r_mc.state == MC_DRAIN) & bus.req_valid));

    assign bus.unit_enable = r_mc.enable;
    assign bus.unit_data1  = r_mc.data1;
    assign bus.unit_data2  = r_mc.data2;
    assign bus.unit_data3  = r_mc.data3;
    assign bus.unit_op     = r_mc.op;
    assign bus.res_valid   = r_mc.res_valid;
    assign bus.res_error   = r_mc.res_error;
    assign bus.res_data    = r_mc.res_data;
    assign bus.res_flags   = r_mc.res_flags;
    assign bus.busy        = (r_mc.state != MC_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_execute_multicycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_execute_multicycle_sequencer
// Description : Randomized self-checking bench against a per-operation
//               timeline model of the multi-cycle sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_execute_multicycle_sequencer;

    localparam int NU = 4;
    localparam int XL = 32;
    localparam int OW = 8;
    localparam int FW = 5;
    localparam int TO = 8;
    localparam int IW = $clog2(NU) + 1;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clock = ~clock;

    execute_multicycle_sequencer_if #(.NUM_UNITS(NU), .XLEN(XL), .OPW(OW), .FLAGW(FW)) bus ();

    execute_multicycle_sequencer #(
        .NUM_UNITS (NU),
        .XLEN      (XL),
        .OPW       (OW),
        .FLAGW     (FW),
        .TIMEOUT   (TO)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        bus.req_valid   = 1'b0;
        bus.req_unit    = '0;
        bus.req_data1   = '0;
        bus.req_data2   = '0;
        bus.req_data3   = '0;
        bus.req_op      = '0;
        bus.clear       = 1'b0;
        bus.hold        = 1'b0;
        bus.unit_ready  = '0;
        bus.unit_result = '0;
        bus.unit_flags  = '0;
    endtask

    // One operation from acceptance (t=0) until the bench sees IDLE again.
    // Phases: 0 idle, 1 wait, 2 done, 3 drain.
    task automatic run_op(input int unit, input int lat, input int clr,
                          input int hold_n, input logic [XL-1:0] rdata);
        logic [XL-1:0]       d1, d2, d3;
        logic [OW-1:0]       op;
        logic [FW-1:0]       rflags;
        logic [NU-1:0]       sel, noise;
        logic [31:0]         rnd;
        logic [NU*XL-1:0]    results;
        logic [NU*FW-1:0]    flags;
        bit                  bad, is_res, is_err;
        int                  w_end, done_s, done_e, drain_e, idle_t, st;

        d1 = $urandom; d2 = $urandom; d3 = $urandom;
        rnd = $urandom; op = rnd[OW-1:0];
        rnd = $urandom; rflags = rnd[FW-1:0];
        bad = (unit >= NU);
        sel = '0;
        if (!bad) sel[unit] = 1'b1;

        is_res = 0; is_err = 0; w_end = 0; done_s = 0; drain_e = -1; idle_t = 0;
        if (bad) begin
            is_err = 1;
            done_s = 1;
        end else if (clr > 0 && clr <= lat && clr <= TO) begin
            w_end = clr;
            if (clr != lat) drain_e = (lat < clr + TO) ? lat : clr + TO;
            idle_t = (drain_e < 0) ? clr + 1 : drain_e + 1;
        end else if (lat <= TO) begin
            is_res = 1;
            w_end  = lat;
            done_s = lat + 1;
        end else begin
            is_err = 1;
            w_end  = TO;
            done_s = TO + 1;
        end
        done_e = done_s + hold_n;
        if (done_s > 0) idle_t = done_e + 1;

        for (int t = 0; t <= idle_t; t++) begin
            @(negedge clock);
            if (t == 0 || t >= idle_t) st = 0;
            else if (t <= w_end)       st = 1;
            else if (done_s > 0)       st = 2;
            else                       st = 3;

            bus.req_valid = (t == 0) ? 1'b1 : ((t < idle_t) ? 1'($urandom_range(0, 1)) : 1'b0);
            rnd = $urandom;
            bus.req_unit  = (t == 0) ? IW'(unit) : rnd[IW-1:0];
            bus.req_data1 = (t == 0) ? d1 : $urandom;
            bus.req_data2 = (t == 0) ? d2 : $urandom;
            bus.req_data3 = (t == 0) ? d3 : $urandom;
            rnd = $urandom;
            bus.req_op    = (t == 0) ? op : rnd[OW-1:0];
            bus.clear     = (t == clr) && (t <= w_end) && (t > 0);
            bus.hold      = (st == 2) ? (t < done_s + hold_n) : 1'($urandom_range(0, 1));

            rnd = $urandom;
            noise = rnd[NU-1:0];
            bus.unit_ready = (noise & ~sel) |
                             (((t == lat) || (t == 0 && rnd[31])) ? sel : '0);
            for (int k = 0; k < NU; k++) begin
                rnd = $urandom;
                results[k*XL +: XL] = $urandom;
                flags[k*FW +: FW]   = rnd[FW-1:0];
            end
            if (t == lat && !bad) begin
                results[unit*XL +: XL] = rdata;
                flags[unit*FW +: FW]   = rflags;
            end
            bus.unit_result = results;
            bus.unit_flags  = flags;

            #1;
            check("unit_enable", 64'(bus.unit_enable), 64'((st == 1) ? sel : '0));
            check("busy",        64'(bus.busy),        64'(st != 0));
            check("stall",       64'(bus.stall),
                  64'((t == 0) || (st == 1) || (st == 3 && bus.req_valid)));
            check("res_valid",   64'(bus.res_valid),   64'(st == 2));
            check("res_error",   64'(bus.res_error),   64'(st == 2 && is_err));
            if (st == 2) begin
                check("res_data",  64'(bus.res_data),  64'(is_res ? rdata : '0));
                check("res_flags", 64'(bus.res_flags), 64'(is_res ? rflags : '0));
            end
            if (st == 1) begin
                check("unit_data1", 64'(bus.unit_data1), 64'(d1));
                check("unit_data2", 64'(bus.unit_data2), 64'(d2));
                check("unit_data3", 64'(bus.unit_data3), 64'(d3));
                check("unit_op",    64'(bus.unit_op),    64'(op));
            end
        end
    endtask

    initial begin
        drive_idle();
        bus.req_valid = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        check("rst_enable", 64'(bus.unit_enable), 64'h0);
        check("rst_busy",   64'(bus.busy),        64'h0);
        check("rst_stall",  64'(bus.stall),       64'h0);
        check("rst_valid",  64'(bus.res_valid),   64'h0);
        check("rst_data",   64'(bus.res_data),    64'h0);
        check("rst_udata",  64'(bus.unit_data1),  64'h0);
        @(negedge clock);
        drive_idle();
        reset = 1'b1;

        run_op(1, 5, 0, 0, 32'h0000_0007);
        run_op(2, 3, 0, 3, 32'hDEAD_BEEF);
        run_op(0, 7, 2, 0, 32'h1234_5678);
        run_op(3, 1000, 0, 1, 32'h0);
        run_op(NU, 1, 0, 0, 32'h0);
        run_op(3, 20, 1, 0, 32'h0);
        run_op(0, 4, 4, 0, 32'h0);
        run_op(2, 1, 0, 0, 32'hCAFE_F00D);

        // Asynchronous reset in the middle of WAIT.
        @(negedge clock);
        bus.req_valid = 1'b1;
        bus.req_unit  = IW'(2);
        bus.req_data1 = 32'hA5A5_A5A5;
        @(negedge clock);
        bus.req_valid = 1'b0;
        @(negedge clock);
        #1;
        check("mid_enable", 64'(bus.unit_enable), 64'h4);
        bus.req_valid = 1'b1;
        #1;
        reset = 1'b0;
        #1;
        check("arst_enable", 64'(bus.unit_enable), 64'h0);
        check("arst_busy",   64'(bus.busy),        64'h0);
        check("arst_stall",  64'(bus.stall),       64'h0);
        check("arst_udata",  64'(bus.unit_data1),  64'h0);
        check("arst_valid",  64'(bus.res_valid),   64'h0);
        @(negedge clock);
        drive_idle();
        reset = 1'b1;
        run_op(2, 2, 0, 0, 32'h0BAD_F00D);

        for (int i = 0; i < 40; i++) begin
            run_op($urandom_range(0, NU),
                   $urandom_range(1, 11),
                   ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0,
                   $urandom_range(0, 3),
                   $urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
